// File: rtl/rs_issue_arbiter_pkg.sv
// Shared types and default sizing for the reservation-station slot arbiter.
package rs_issue_arbiter_pkg;

    typedef enum logic {
        RS_SEL_FIXED = 1'b0,
        RS_SEL_RR    = 1'b1
    } sel_mode_e;

    localparam int RS_SIZE_DEF       = 16;
    localparam int RS_SIZE_WIDTH_DEF = 4;
    localparam int ISSUE_WIDTH_DEF   = 2;

endpackage

// File: rtl/rs_issue_arbiter_if.sv
// Bundle between the reservation station / dispatcher / execution units and the slot arbiter.
interface rs_issue_arbiter_if
    import rs_issue_arbiter_pkg::*;
#(
    parameter int RS_SIZE       = RS_SIZE_DEF,
    parameter int RS_SIZE_WIDTH = RS_SIZE_WIDTH_DEF,
    parameter int ISSUE_WIDTH   = ISSUE_WIDTH_DEF
);
    logic                                   rdy;
    logic                                   flush;
    logic [RS_SIZE-1:0]                     busy;
    logic [RS_SIZE-1:0]                     ready;
    logic                                   alloc_fire;
    logic                                   has_free_rs_line;
    logic [RS_SIZE_WIDTH-1:0]               free_rs_line;
    logic [ISSUE_WIDTH-1:0]                 exe_valid;
    logic [ISSUE_WIDTH*RS_SIZE_WIDTH-1:0]   exe_line;
    logic [ISSUE_WIDTH-1:0]                 exe_ack;

    modport master (
        output rdy, flush, busy, ready, alloc_fire, exe_ack,
        input  has_free_rs_line, free_rs_line, exe_valid, exe_line
    );

    modport slave (
        input  rdy, flush, busy, ready, alloc_fire, exe_ack,
        output has_free_rs_line, free_rs_line, exe_valid, exe_line
    );
endinterface

// File: rtl/rs_prio_pick.sv
// Masked priority encoder: returns the first set bit of mask, searching upward from base with wrap.
module rs_prio_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] index
);
    logic [W-1:0] probe;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found = 1'b0;
        index = '0;
        probe = '0;
        for (int i = 0; i < N; i++) begin
            probe = base + W'(i);
            if (!found && mask[probe]) begin
                found = 1'b1;
                index = probe;
            end
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// RS slot arbiter: registered lowest-free-line pick for dispatch and up to ISSUE_WIDTH issue grants.
module rs_issue_arbiter
    import rs_issue_arbiter_pkg::*;
#(
    parameter int        RS_SIZE       = RS_SIZE_DEF,
    parameter int        RS_SIZE_WIDTH = RS_SIZE_WIDTH_DEF,
    parameter int        ISSUE_WIDTH   = ISSUE_WIDTH_DEF,
    parameter sel_mode_e SEL_MODE      = RS_SEL_RR
) (
    input  logic              clk,
    input  logic              rst,
    rs_issue_arbiter_if.slave bus
);
    localparam int W = RS_SIZE_WIDTH;

    logic                          has_free_q;
    logic [W-1:0]                  free_q;
    logic [RS_SIZE-1:0]            alloc_pending_q;
    logic [RS_SIZE-1:0]            issued_q;
    logic [W-1:0]                  rr_ptr_q;
    logic [ISSUE_WIDTH-1:0]        exe_valid_q;
    logic [ISSUE_WIDTH*W-1:0]      exe_line_q;

    logic [RS_SIZE-1:0]            fire_mask;
    logic [RS_SIZE-1:0]            cand_free;
    logic [RS_SIZE-1:0]            cand_exe;
    logic [RS_SIZE-1:0]            grant_mask;
    logic                          free_found;
    logic [W-1:0]                  free_idx;
    logic [W-1:0]                  exe_base;
    logic [ISSUE_WIDTH-1:0]        port_open;
    logic [ISSUE_WIDTH-1:0]        grant_vec;
    logic [ISSUE_WIDTH*W-1:0]      grant_line;
    logic [W-1:0]                  rr_next;

    // The line handed to the dispatcher this cycle is masked so it cannot be offered twice.
    assign fire_mask = bus.alloc_fire ? (RS_SIZE'(1) << free_q) : '0;
    assign cand_free = ~bus.busy & ~alloc_pending_q & ~fire_mask;
    assign cand_exe  = bus.busy & bus.ready & ~issued_q;
    assign exe_base  = (SEL_MODE == RS_SEL_RR) ? rr_ptr_q : '0;
    assign port_open = ~exe_valid_q | bus.exe_ack;

    rs_prio_pick #(.N(RS_SIZE), .W(W)) u_free_pick (
        .mask  (cand_free),
        .base  ('0),
        .found (free_found),
        .index (free_idx)
    );

    for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_port
        logic [RS_SIZE-1:0] avail;
        logic [RS_SIZE-1:0] taken;
        logic               pick_found;
        logic [W-1:0]       pick_idx;
        logic               grant;

        rs_prio_pick #(.N(RS_SIZE), .W(W)) u_exe_pick (
            .mask  (avail),
            .base  (exe_base),
            .found (pick_found),
            .index (pick_idx)
        );

        // A flush suppresses new grants so rr_ptr holds and nothing lands in issued.
        assign grant = port_open[p] & pick_found & ~bus.flush;

        if (p == 0) begin : g_first
            assign avail = cand_exe;
            assign taken = grant ? (RS_SIZE'(1) << pick_idx) : '0;
        end else begin : g_next
            assign avail = cand_exe & ~g_port[p-1].taken;
            assign taken = g_port[p-1].taken | (grant ? (RS_SIZE'(1) << pick_idx) : '0);
        end

        assign grant_vec[p]          = grant;
        assign grant_line[p*W +: W]  = pick_idx;
    end

    assign grant_mask = g_port[ISSUE_WIDTH-1].taken;

    always_comb begin
        rr_next = rr_ptr_q;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (grant_vec[p]) rr_next = grant_line[p*W +: W] + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_free_q      <= 1'b0;
            free_q          <= '0;
            alloc_pending_q <= '0;
            issued_q        <= '0;
            rr_ptr_q        <= '0;
            exe_valid_q     <= '0;
            exe_line_q      <= '0;
        end else if (bus.rdy) begin
            has_free_q <= free_found;
            free_q     <= free_found ? free_idx : '0;
            rr_ptr_q   <= rr_next;
            if (bus.flush) begin
                alloc_pending_q <= '0;
                issued_q        <= '0;
                exe_valid_q     <= '0;
                exe_line_q      <= '0;
            end else begin
                alloc_pending_q <= (alloc_pending_q & ~bus.busy) | fire_mask;
                issued_q        <= (issued_q & bus.busy) | grant_mask;
                for (int p = 0; p < ISSUE_WIDTH; p++) begin
                    if (port_open[p]) begin
                        exe_valid_q[p]         <= grant_vec[p];
                        exe_line_q[p*W +: W]   <= grant_vec[p] ? grant_line[p*W +: W] : '0;
                    end
                end
            end
        end
    end

    assign bus.has_free_rs_line = has_free_q;
    assign bus.free_rs_line     = free_q;
    assign bus.exe_valid        = exe_valid_q;
    assign bus.exe_line         = exe_line_q;

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Randomised and directed bench for rs_issue_arbiter; a round-robin and a fixed-priority instance share stimulus.
module tb_rs_issue_arbiter;
    import rs_issue_arbiter_pkg::*;

    localparam int N = 8;
    localparam int W = 3;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         rdy, flush, fire;
    logic [N-1:0] busy, ready;
    logic [P-1:0] ack;

    int tests  = 0;
    int failed = 0;

    rs_issue_arbiter_if #(.RS_SIZE(N), .RS_SIZE_WIDTH(W), .ISSUE_WIDTH(P)) bus_rr ();
    rs_issue_arbiter_if #(.RS_SIZE(N), .RS_SIZE_WIDTH(W), .ISSUE_WIDTH(P)) bus_fx ();

    assign bus_rr.rdy = rdy;   assign bus_rr.flush = flush; assign bus_rr.alloc_fire = fire;
    assign bus_rr.busy = busy; assign bus_rr.ready = ready; assign bus_rr.exe_ack = ack;
    assign bus_fx.rdy = rdy;   assign bus_fx.flush = flush; assign bus_fx.alloc_fire = fire;
    assign bus_fx.busy = busy; assign bus_fx.ready = ready; assign bus_fx.exe_ack = ack;

    rs_issue_arbiter #(.RS_SIZE(N), .RS_SIZE_WIDTH(W), .ISSUE_WIDTH(P), .SEL_MODE(RS_SEL_RR))
        u_dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    rs_issue_arbiter #(.RS_SIZE(N), .RS_SIZE_WIDTH(W), .ISSUE_WIDTH(P), .SEL_MODE(RS_SEL_FIXED))
        u_dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));

    // Reference model state; index 0 = round-robin instance, 1 = fixed-priority instance.
    bit m_has_free [2];
    int m_free     [2];
    bit m_pend     [2][N];
    bit m_iss      [2][N];
    int m_rr       [2];
    bit m_valid    [2][P];
    int m_line     [2][P];

    function automatic logic [11:0] act_vec(int k);
        if (k == 0) return {bus_rr.has_free_rs_line, bus_rr.free_rs_line, bus_rr.exe_valid, bus_rr.exe_line};
        return {bus_fx.has_free_rs_line, bus_fx.free_rs_line, bus_fx.exe_valid, bus_fx.exe_line};
    endfunction

    function automatic logic [11:0] exp_vec(int k);
        return {m_has_free[k], 3'(m_free[k]), m_valid[k][1], m_valid[k][0], 3'(m_line[k][1]), 3'(m_line[k][0])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_has_free[k] = 0; m_free[k] = 0; m_rr[k] = 0;
            for (int i = 0; i < N; i++) begin m_pend[k][i] = 0; m_iss[k][i] = 0; end
            for (int p = 0; p < P; p++) begin m_valid[k][p] = 0; m_line[k][p] = 0; end
        end
    endtask

    // One clock of the specified behaviour, using the inputs applied before the edge.
    task automatic model_step(int k);
        bit         nf_found = 0;
        int         nf = 0;
        bit [N-1:0] taken = '0;
        bit         any = 0;
        int         last = 0;
        bit         n_valid [P];
        int         n_line  [P];
        if (!rdy) return;
        for (int i = 0; i < N; i++)
            if (!nf_found && !busy[i] && !m_pend[k][i] && !(fire && i == m_free[k])) begin
                nf_found = 1; nf = i;
            end
        for (int p = 0; p < P; p++) begin
            n_valid[p] = m_valid[k][p];
            n_line[p]  = m_line[k][p];
            if (flush) begin
                n_valid[p] = 0; n_line[p] = 0;
            end else if (!m_valid[k][p] || ack[p]) begin
                int start = (k == 0) ? m_rr[k] : 0;
                n_valid[p] = 0; n_line[p] = 0;
                for (int j = 0; j < N; j++) begin
                    int l = (start + j) % N;
                    if (!n_valid[p] && busy[l] && ready[l] && !m_iss[k][l] && !taken[l]) begin
                        n_valid[p] = 1; n_line[p] = l; taken[l] = 1; any = 1; last = l;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[k][i] = flush ? 0 : (m_pend[k][i] && !busy[i]);
            m_iss[k][i]  = flush ? 0 : ((m_iss[k][i] && busy[i]) || taken[i]);
        end
        if (!flush && fire) m_pend[k][m_free[k]] = 1;
        if (any) m_rr[k] = (last + 1) % N;
        for (int p = 0; p < P; p++) begin m_valid[k][p] = n_valid[p]; m_line[k][p] = n_line[p]; end
        m_has_free[k] = nf_found;
        m_free[k]     = nf;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else begin model_step(0); model_step(1); end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 0; fire = 0; busy = '0; ready = '0; ack = '0;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (act_vec(k) !== 12'h000) begin
                failed++; $display("FAIL reset_state[%0d]: got %h, expected 000", k, act_vec(k));
            end
        end
        @(negedge clk); rst = 1'b0;
        busy = 8'hFF; ready = 8'b0000_1100;
        cycle();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                failed++; $display("FAIL pre_reset_grant[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k));
            end
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (act_vec(k) !== 12'h000) begin
                failed++; $display("FAIL async_reset[%0d]: got %h, expected 000", k, act_vec(k));
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_rr_issue();
        busy = 8'hFF; ready = 8'b0010_0100; ack = 2'b11;
        cycle();
        tests++;
        if ({bus_rr.exe_valid, bus_rr.exe_line} !== {2'b11, 3'd5, 3'd2}) begin
            failed++; $display("FAIL rr_two_ports: got %b/%h, expected 11/2a", bus_rr.exe_valid, bus_rr.exe_line);
        end
        ready = 8'b0000_0101;
        cycle();
        tests++;
        if ({bus_rr.exe_valid, bus_rr.exe_line} !== {2'b01, 6'd0}) begin
            failed++; $display("FAIL rr_issued_mask: got %b/%h, expected 01/00", bus_rr.exe_valid, bus_rr.exe_line);
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                failed++; $display("FAIL rr_issue_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_hold();
        busy = '0; ready = '0; ack = 2'b11;
        cycle();
        busy = 8'hFF; ready = 8'b0000_0100; ack = 2'b00;
        cycle();
        ack = 2'b10; ready = 8'b0000_0110;
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests++;
            if (!(bus_rr.exe_valid[0] === 1'b1 && bus_rr.exe_line[2:0] === 3'd2 &&
                  !(bus_rr.exe_valid[1] === 1'b1 && bus_rr.exe_line[5:3] === 3'd2))) begin
                failed++; $display("FAIL hold_port0 c%0d: got %b/%h, expected port0 line 2 held", c, bus_rr.exe_valid, bus_rr.exe_line);
            end
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    failed++; $display("FAIL hold_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_free_path();
        logic [W-1:0] want [4] = '{3'd2, 3'd3, 3'd3, 3'd2};
        logic [N-1:0] bz   [4] = '{8'b0000_0011, 8'b0000_0011, 8'b0000_0111, 8'b0000_0011};
        bit           fr   [4] = '{0, 1, 0, 0};
        ack = 2'b11; ready = '0;
        for (int s = 0; s < 4; s++) begin
            busy = bz[s]; fire = fr[s];
            cycle();
            tests++;
            if (bus_rr.has_free_rs_line !== 1'b1 || bus_rr.free_rs_line !== want[s]) begin
                failed++; $display("FAIL free_step%0d: got %b/%0d, expected 1/%0d", s, bus_rr.has_free_rs_line, bus_rr.free_rs_line, want[s]);
            end
        end
        fire = 0;
    endtask

    task automatic test_rdy_freeze();
        logic [11:0] snap [2];
        busy = 8'hFF; ready = '0;
        cycle();
        tests++;
        if (bus_rr.has_free_rs_line !== 1'b0 || bus_rr.free_rs_line !== 3'd0) begin
            failed++; $display("FAIL full_rs: got %b/%0d, expected 0/0", bus_rr.has_free_rs_line, bus_rr.free_rs_line);
        end
        snap[0] = exp_vec(0); snap[1] = exp_vec(1);
        rdy = 0; flush = 1; fire = 1;
        for (int c = 0; c < 2; c++) begin
            ready = 8'($urandom); ack = 2'($urandom); busy = 8'($urandom);
            cycle();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (act_vec(k) !== snap[k] || act_vec(k) !== exp_vec(k)) begin
                    failed++; $display("FAIL rdy_freeze[%0d]: got %h, expected %h", k, act_vec(k), snap[k]);
                end
            end
        end
        rdy = 1; flush = 0; fire = 0;
    endtask

    task automatic test_flush();
        busy = '0; ready = '0; ack = 2'b11;
        cycle();
        busy = 8'hFF; ready = 8'b0000_0100; ack = 2'b00;
        cycle();
        flush = 1;
        cycle();
        tests++;
        if (bus_rr.exe_valid !== 2'b00 || bus_rr.exe_line !== 6'd0) begin
            failed++; $display("FAIL flush_drop: got %b/%h, expected 00/00", bus_rr.exe_valid, bus_rr.exe_line);
        end
        flush = 0;
        cycle();
        tests++;
        if (bus_rr.exe_valid[0] !== 1'b1 || bus_rr.exe_line[2:0] !== 3'd2) begin
            failed++; $display("FAIL flush_regrant: got %b/%h, expected port0 line 2", bus_rr.exe_valid, bus_rr.exe_line);
        end
        busy = '0; ack = 2'b11;
        cycle();
        busy = 8'hFF; ready = 8'b1000_0001;
        cycle();
        tests++;
        if ({bus_fx.exe_valid, bus_fx.exe_line} !== {2'b11, 3'd7, 3'd0}) begin
            failed++; $display("FAIL fixed_prio: got %b/%h, expected 11/38", bus_fx.exe_valid, bus_fx.exe_line);
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                failed++; $display("FAIL flush_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        busy = '0; ready = '0; ack = '0; flush = 0; fire = 0; rdy = 1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) busy[i] = ~busy[i];
            ready = 8'($urandom);
            ack   = 2'($urandom);
            rdy   = ($urandom_range(7) != 0);
            flush = ($urandom_range(15) == 0);
            fire  = m_has_free[0] && ($urandom_range(2) == 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    failed++; $display("FAIL random c%0d[%0d]: got %h, expected %h", c, k, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_issue();
        test_hold();
        test_free_path();
        test_rdy_freeze();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
